// File: rtl/register_bank_scoreboard_if.sv
// -----------------------------------------------------------------------------
// register_bank_scoreboard_if
// Bundles the decoder issue port, the ALU writeback port, the flush control and
// the register/scoreboard outputs of the register bank.
//   master : decoder / ALU side (drives issue, writeback and flush; reads outputs)
//   slave  : register bank side
// Signals
//   flush                     clear all pending bits, contents kept
//   issue_valid/issue_ready   issue handshake (ready is combinational)
//   issue_dst/src_a/src_b     3-bit register indices (0=A .. 7=H)
//   issue_use_b               1: side-B reads a register, 0: side-B is IMM8
//   wb_valid/wb_sel/wb_data   ALU result writeback
//   reg_a..reg_h              register contents to the operand muxes
//   pending                   scoreboard bit per register
//   wb_err                    sticky writeback-to-idle-register flag
// -----------------------------------------------------------------------------
interface register_bank_scoreboard_if #(
  parameter int WORD_SIZE = 8
);
  logic                 flush;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [2:0]           issue_dst;
  logic [2:0]           issue_src_a;
  logic [2:0]           issue_src_b;
  logic                 issue_use_b;
  logic                 wb_valid;
  logic [2:0]           wb_sel;
  logic [WORD_SIZE-1:0] wb_data;
  logic [WORD_SIZE-1:0] reg_a;
  logic [WORD_SIZE-1:0] reg_b;
  logic [WORD_SIZE-1:0] reg_c;
  logic [WORD_SIZE-1:0] reg_d;
  logic [WORD_SIZE-1:0] reg_e;
  logic [WORD_SIZE-1:0] reg_f;
  logic [WORD_SIZE-1:0] reg_g;
  logic [WORD_SIZE-1:0] reg_h;
  logic [7:0]           pending;
  logic                 wb_err;

  modport master (
    output flush, issue_valid, issue_dst, issue_src_a, issue_src_b, issue_use_b,
    output wb_valid, wb_sel, wb_data,
    input  issue_ready, reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h,
    input  pending, wb_err
  );

  modport slave (
    input  flush, issue_valid, issue_dst, issue_src_a, issue_src_b, issue_use_b,
    input  wb_valid, wb_sel, wb_data,
    output issue_ready, reg_a, reg_b, reg_c, reg_d, reg_e, reg_f, reg_g, reg_h,
    output pending, wb_err
  );
endinterface

// File: rtl/register_bank_scoreboard.sv
// -----------------------------------------------------------------------------
// register_bank_scoreboard
// Eight-entry general register bank (A..H) with an issue scoreboard. Each
// register has a pending bit set when an instruction targeting it issues and
// cleared when its ALU result is written back. Issue stalls while any source
// (side-B only when it reads a register) or the destination is pending.
// Ports
//   clk    rising-edge clock
//   reset  synchronous active-high reset (overrides flush/issue/wb)
//   bus    register_bank_scoreboard_if.slave (issue, writeback, flush, outputs)
// Configuration macro
//   REGBANK_WB_BYPASS_EN : a same-cycle writeback counts as clearing the
//   pending bit for issue_ready, and reg_x outputs are write-through.
//   Undefined (default): registered outputs and registered-only pending.
// -----------------------------------------------------------------------------
module register_bank_scoreboard #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 8   // fixed at 8: selectors are 3 bits wide
) (
  input  logic                         clk,
  input  logic                         reset,
  register_bank_scoreboard_if.slave    bus
);

  logic [WORD_SIZE-1:0] regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]  pending_r;
  logic                 wb_err_r;

  logic [NUM_REGS-1:0]  wb_hit_s;
  logic [NUM_REGS-1:0]  fire_hit_s;
  logic [NUM_REGS-1:0]  pend_eff_s;
  logic [NUM_REGS-1:0]  pending_nxt_s;
  logic                 ready_s;
  logic                 fire_s;
  logic                 err_set_s;
  logic [WORD_SIZE-1:0] rd_s [NUM_REGS];

  function automatic logic [NUM_REGS-1:0] onehot(input logic [2:0] idx);
    onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Writeback decode, issue readiness and next scoreboard state
  always_comb begin
    wb_hit_s = {NUM_REGS{1'b0}};
    if (bus.wb_valid) begin
      wb_hit_s = onehot(bus.wb_sel);
    end else begin
      wb_hit_s = {NUM_REGS{1'b0}};
    end

`ifdef REGBANK_WB_BYPASS_EN
    // A result arriving this cycle already satisfies the dependency.
    pend_eff_s = pending_r & ~wb_hit_s;
`else
    pend_eff_s = pending_r;
`endif

    // Destination term blocks WAW; side-B is only checked when it reads a register.
    ready_s = ~pend_eff_s[bus.issue_src_a]
            & ~(bus.issue_use_b & pend_eff_s[bus.issue_src_b])
            & ~pend_eff_s[bus.issue_dst];
    fire_s  = bus.issue_valid & ready_s;

    fire_hit_s = {NUM_REGS{1'b0}};
    if (fire_s) begin
      fire_hit_s = onehot(bus.issue_dst);
    end else begin
      fire_hit_s = {NUM_REGS{1'b0}};
    end

    // Flush beats a same-cycle issue; otherwise a new issue beats a same-register clear.
    pending_nxt_s = {NUM_REGS{1'b0}};
    if (bus.flush) begin
      pending_nxt_s = {NUM_REGS{1'b0}};
    end else begin
      pending_nxt_s = (pending_r & ~wb_hit_s) | fire_hit_s;
    end

    err_set_s = bus.wb_valid & ~pending_r[bus.wb_sel] & ~bus.flush;
  end

  // Register file, scoreboard and sticky error state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {WORD_SIZE{1'b0}};
      end
      pending_r <= {NUM_REGS{1'b0}};
      wb_err_r  <= 1'b0;
    end else begin
      if (bus.wb_valid) begin
        regs_r[bus.wb_sel] <= bus.wb_data;
      end
      pending_r <= pending_nxt_s;
      if (err_set_s) begin
        wb_err_r <= 1'b1;
      end
    end
  end

  // Register read view presented to the operand muxes
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_s[i] = regs_r[i];
`ifdef REGBANK_WB_BYPASS_EN
      if (wb_hit_s[i]) begin
        rd_s[i] = bus.wb_data;
      end else begin
        rd_s[i] = regs_r[i];
      end
`endif
    end
  end

  assign bus.reg_a       = rd_s[0];
  assign bus.reg_b       = rd_s[1];
  assign bus.reg_c       = rd_s[2];
  assign bus.reg_d       = rd_s[3];
  assign bus.reg_e       = rd_s[4];
  assign bus.reg_f       = rd_s[5];
  assign bus.reg_g       = rd_s[6];
  assign bus.reg_h       = rd_s[7];
  assign bus.pending     = pending_r;
  assign bus.wb_err      = wb_err_r;
  assign bus.issue_ready = ready_s;

endmodule

// File: tb/tb_register_bank_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_register_bank_scoreboard
// Stimulus drives one cycle at a time and pushes the expected view of that
// cycle (issue_ready, pending, wb_err, all registers) computed by an
// array-based reference model; a monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_register_bank_scoreboard;

`ifdef REGBANK_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  register_bank_scoreboard_if #(.WORD_SIZE(8)) bus ();

  register_bank_scoreboard #(.WORD_SIZE(8), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rdy;
    logic [7:0]  pend;
    logic        err;
    logic [63:0] regs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  bit [7:0] m_reg [8];
  bit       m_pend [8];
  bit       m_err;
  bit       m_init = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare the DUT view of each cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("issue_ready", {63'd0, bus.issue_ready}, {63'd0, e.rdy});
      check("pending", {56'd0, bus.pending}, {56'd0, e.pend});
      check("wb_err", {63'd0, bus.wb_err}, {63'd0, e.err});
      check("regs", {bus.reg_h, bus.reg_g, bus.reg_f, bus.reg_e,
                     bus.reg_d, bus.reg_c, bus.reg_b, bus.reg_a}, e.regs);
    end
  end

  function automatic bit blocked(input int idx, input bit wv, input int ws);
    return m_pend[idx] && !(BYPASS && wv && (ws == idx));
  endfunction

  task automatic step(input bit rst, input bit fl, input bit iv, input int d, input int sa,
                      input int sb, input bit ub, input bit wv, input int ws, input int wd);
    exp_t e;
    bit   rdy;
    bit [7:0] wdb;
    @(posedge clk);
    #1;
    wdb = wd[7:0];
    reset           = rst;
    bus.flush       = fl;
    bus.issue_valid = iv;
    bus.issue_dst   = d[2:0];
    bus.issue_src_a = sa[2:0];
    bus.issue_src_b = sb[2:0];
    bus.issue_use_b = ub;
    bus.wb_valid    = wv;
    bus.wb_sel      = ws[2:0];
    bus.wb_data     = wdb;

    rdy = !blocked(sa, wv, ws) && !(ub && blocked(sb, wv, ws)) && !blocked(d, wv, ws);
    if (m_init) begin
      e.rdy = rdy;
      e.err = m_err;
      for (int i = 0; i < 8; i++) begin
        e.pend[i] = m_pend[i];
        e.regs[i*8 +: 8] = (BYPASS && wv && ws == i) ? wdb : m_reg[i];
      end
      exp_q.push_back(e);
    end

    // state after the coming edge
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_reg[i] = 8'h00;
        m_pend[i] = 1'b0;
      end
      m_err  = 1'b0;
      m_init = 1'b1;
    end else begin
      if (wv) begin
        if (!m_pend[ws] && !fl) m_err = 1'b1;
        m_reg[ws]  = wdb;
        m_pend[ws] = 1'b0;
      end
      if (fl) begin
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      end else if (iv && rdy) begin
        m_pend[d] = 1'b1;
      end
    end
  endtask

  // shorthands: plain issue, writeback only, idle
  task automatic iss(input int d, input int sa, input int sb, input bit ub);
    step(1'b0, 1'b0, 1'b1, d, sa, sb, ub, 1'b0, 0, 0);
  endtask

  task automatic wbk(input int ws, input int wd);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, ws, wd);
  endtask

  initial begin
    int pq[$];
    int ws;
    bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_dst = 3'd0;
    bus.issue_src_a = 3'd0; bus.issue_src_b = 3'd0; bus.issue_use_b = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_sel = 3'd0; bus.wb_data = 8'h00;

    // 1: reset, then readiness for assorted indices
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 7, 3, 5, 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1, 6, 2, 1'b0, 1'b0, 0, 0);

    // 2: RAW stall on C, released by writeback
    iss(2, 0, 1, 1'b1);
    iss(0, 2, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0, 2, 0, 1'b0, 1'b1, 2, 8'h5A);
    iss(1, 2, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

    // 3: side-B checked only when it reads a register
    iss(3, 1, 1, 1'b0);
    iss(4, 0, 3, 1'b0);
    iss(5, 0, 3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

    // 4: same-cycle writeback and issue to F
    iss(5, 0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 5, 0, 0, 1'b0, 1'b1, 5, 8'h11);
    step(1'b0, 1'b0, 1'b1, 5, 0, 0, 1'b0, 1'b1, 5, 8'h22);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

    // 5: writeback to an idle register raises sticky wb_err
    wbk(6, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    iss(1, 0, 0, 1'b0);
    wbk(1, 8'h33);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);

    // 6: flush beats issue; writeback under flush does not raise wb_err; reset mid-stall
    iss(0, 1, 1, 1'b0);
    iss(7, 1, 1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1, 2, 2, 1'b0, 1'b1, 4, 8'h44);
    iss(2, 3, 3, 1'b0);
    iss(3, 2, 2, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3, 2, 2, 1'b0, 1'b0, 0, 0);
    iss(3, 2, 2, 1'b0);

    // randomized traffic, writebacks biased towards pending registers
    for (int n = 0; n < 1500; n++) begin
      pq.delete();
      for (int i = 0; i < 8; i++) if (m_pend[i]) pq.push_back(i);
      ws = $urandom_range(0, 7);
      if (pq.size() > 0 && $urandom_range(0, 3) != 0) ws = pq[$urandom_range(0, pq.size() - 1)];
      step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ws, $urandom_range(0, 255));
    end

    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
